// File: rtl/instr_loader.sv
// Serializes 64-bit host instruction words into MSB-first byte writes to the unified memory.
// Optional running byte checksum is built only when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_loader #(
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_WIDTH = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int APPEND_TERM = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [INSTR_WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_grant,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [ADDR_WIDTH-1:0]  word_count,
  output logic [DATA_WIDTH-1:0]  checksum
);

  localparam int BYTES = INSTR_WIDTH / DATA_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_TERM   = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [INSTR_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   ovf_q, ovf_d;

  logic                   wr_s;
  logic                   byte_last_s;
  logic [DATA_WIDTH-1:0]  byte_s;

  assign wr_s        = (state_q == S_WRITE) || (state_q == S_TERM);
  assign byte_last_s = (cnt_q == CNT_LAST);
  assign byte_s      = (state_q == S_TERM) ? {DATA_WIDTH{1'b0}}
                                           : shift_q[INSTR_WIDTH-1 -: DATA_WIDTH];

  // Next-state and datapath updates for the load session
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          wcnt_d  = {ADDR_WIDTH{1'b0}};
          ovf_d   = 1'b0;
          state_d = S_ACCEPT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCEPT: begin
        if (s_valid) begin
          shift_d = s_data;
          last_d  = s_last;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_WRITE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_WRITE, S_TERM: begin
        if (mem_grant) begin
          addr_d  = addr_q + ADDR_ONE;
          shift_d = shift_q << DATA_WIDTH;
          cnt_d   = byte_last_s ? {CNT_W{1'b0}} : (cnt_q + CNT_ONE);
          if ((state_q == S_WRITE) && byte_last_s) begin
            wcnt_d = wcnt_q + ADDR_ONE;
          end else begin
            wcnt_d = wcnt_q;
          end
          // The top address is still written, but nothing may follow it
          if (addr_q == ADDR_MAX) begin
            ovf_d   = 1'b1;
            state_d = S_FIN;
          end else if (!byte_last_s) begin
            state_d = state_q;
          end else if (state_q == S_TERM) begin
            state_d = S_FIN;
          end else if (!last_q) begin
            state_d = S_ACCEPT;
          end else if (APPEND_TERM != 0) begin
            state_d = S_TERM;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Session state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wcnt_q  <= {ADDR_WIDTH{1'b0}};
      shift_q <= {INSTR_WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s_ready    = (state_q == S_ACCEPT);
  assign mem_req    = wr_s;
  assign mem_we     = wr_s;
  assign mem_addr   = addr_q;
  assign mem_wdata  = byte_s;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign overflow   = ovf_q;
  assign word_count = wcnt_q;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  // Running sum of every granted byte; terminator bytes add zero
  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE) && start) begin
      csum_d = {DATA_WIDTH{1'b0}};
    end else if (wr_s && mem_grant) begin
      csum_d = csum_q + byte_s;
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= {DATA_WIDTH{1'b0}};
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a byte-stream model predicts every memory write,
// a negedge monitor pops and compares each granted write and checks hold behaviour.
module tb_instr_loader;

  localparam int TB_APPEND_TERM = 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_grant;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] word_count;
  logic [7:0]  checksum;

  instr_loader #(
    .DATA_WIDTH (8),
    .INSTR_WIDTH(64),
    .ADDR_WIDTH (16),
    .APPEND_TERM(TB_APPEND_TERM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_grant (mem_grant),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .word_count(word_count),
    .checksum  (checksum)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          gcount = 0;
  int          done_pulses = 0;
  bit          grant_rnd = 1'b0;
  bit          written [0:65535];
  wr_t         exp_q[$];
  logic [63:0] words[$];
  logic [15:0] exp_wc;
  logic        exp_ovf;
  logic [7:0]  exp_cs;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    mem_grant = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_grant = grant_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec = n_vec + 1;
    if (act !== req) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {s_ready, mem_req, mem_we, busy, done, overflow}, 64'h0);
    chk({tag, "_mem_addr"}, mem_addr, 64'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    chk({tag, "_word_count"}, word_count, 64'h0);
    chk({tag, "_checksum"}, checksum, 64'h0);
  endtask

  // Model: the program is one byte stream (words MSB first, then the zero terminator)
  // laid out from base upward and cut off after the last address of the space.
  task automatic build_model(input logic [15:0] base);
    logic [7:0] stream[$];
    int avail, nw;
    wr_t e;
    stream = {};
    foreach (words[w]) begin
      for (int b = 0; b < 8; b++) stream.push_back(words[w][63-8*b -: 8]);
    end
    if (TB_APPEND_TERM != 0) begin
      for (int b = 0; b < 8; b++) stream.push_back(8'h00);
    end
    avail   = 65536 - int'(base);
    nw      = (stream.size() < avail) ? stream.size() : avail;
    exp_ovf = (stream.size() >= avail);
    exp_wc  = 16'(((nw / 8) < words.size()) ? (nw / 8) : words.size());
    exp_cs  = 8'h00;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      e.a = base + 16'(i);
      e.d = stream[i];
      exp_q.push_back(e);
      exp_cs = exp_cs + stream[i];
    end
    for (int i = 0; i < 65536; i++) written[i] = 1'b0;
  endtask

  // Monitor: every granted write must be the next predicted byte, never repeated
  initial begin
    wr_t  e;
    logic p_hold;
    logic [15:0] p_addr;
    logic [7:0]  p_data;
    p_hold = 1'b0;
    p_addr = 16'h0;
    p_data = 8'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_hold = 1'b0;
      end else begin
        if (p_hold) begin
          chk("hold_req", mem_req, 64'h1);
          chk("hold_addr", mem_addr, p_addr);
          chk("hold_wdata", mem_wdata, p_data);
        end
        if (mem_req) chk("s_ready_low_while_writing", s_ready, 64'h0);
        chk("we_equals_req", mem_we, mem_req);
        if (done) done_pulses = done_pulses + 1;
        if (mem_req && mem_grant) begin
          if (exp_q.size() == 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL extra_write: got write %0h=%0h, expected no write", mem_addr, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", mem_addr, e.a);
            chk("write_data", mem_wdata, e.d);
          end
          chk("no_double_write", written[mem_addr], 64'h0);
          written[mem_addr] = 1'b1;
          gcount = gcount + 1;
        end
        p_hold = mem_req && !mem_grant;
        p_addr = mem_addr;
        p_data = mem_wdata;
      end
    end
  end

  // One complete session; lat >= 0 checks the accept-to-done distance in clock edges
  task automatic run_session(input logic [15:0] base, input bit rnd, input bit poke,
                             input bit idle_valid, input int lat);
    int  w, acc_cyc, done_cyc;
    bit  got_done;
    logic [7:0] cs_req;
    build_model(base);
    grant_rnd   = rnd;
    done_pulses = 0;
    acc_cyc     = 0;
    done_cyc    = 0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    cs_req = exp_cs;
`else
    cs_req = 8'h00;
`endif
    if (idle_valid) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = 64'hDEADBEEFCAFEF00D; s_last = 1'b1;
      @(negedge clk);
      chk("idle_s_ready", s_ready, 64'h0);
      chk("idle_busy", busy, 64'h0);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      @(negedge clk);
      chk("idle_valid_ignored", {busy, mem_req}, 64'h0);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 16'($urandom);
    w = 0;
    s_valid = 1'b1; s_data = words[0]; s_last = (words.size() == 1);
    got_done = 1'b0;
    for (int t = 0; t < 6000 && !got_done; t++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        chk("word_count", word_count, exp_wc);
        chk("overflow", overflow, exp_ovf);
        chk("checksum", checksum, cs_req);
        chk("writes_outstanding", exp_q.size(), 64'h0);
        chk("no_req_in_fin", mem_req, 64'h0);
      end else if (s_valid && s_ready) begin
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        w = w + 1;
        if (poke && w == 1) begin
          start = 1'b1; base_addr = ~base;
        end
        if (w < words.size()) begin
          s_data = words[w]; s_last = (w == words.size() - 1);
        end else begin
          s_valid = 1'b0; s_last = 1'b0;
        end
      end else if (start) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    chk("done_seen", got_done, 64'h1);
    if (got_done && lat >= 0) chk("done_latency", done_cyc - acc_cyc, lat);
    @(negedge clk); #1;
    chk("done_one_cycle", {done, busy}, 64'h0);
    chk("done_pulse_count", done_pulses, 64'h1);
  endtask

  initial begin
    logic [15:0] b;
    rst_n = 1'b0; start = 1'b0; base_addr = 16'h0;
    s_valid = 1'b0; s_data = 64'h0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed one-word program; done lands 16 edges after the accepting edge
    words = {64'h0102030405060708};
    run_session(16'h0100, 1'b0, 1'b0, 1'b0, 16);

    // Three back-to-back words, then the same words under a 50% grant
    words = {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    run_session(16'h2000, 1'b0, 1'b0, 1'b0, -1);
    run_session(16'h2000, 1'b1, 1'b0, 1'b0, -1);

    // Wrap at the top of the address space
    words = {64'h0102030405060708};
    run_session(16'hFFFC, 1'b0, 1'b0, 1'b0, -1);

    // start while busy and s_valid while idle are both ignored
    words = {{$urandom, $urandom}, {$urandom, $urandom}};
    run_session(16'h3000, 1'b1, 1'b1, 1'b1, -1);

    // Reset after the third granted byte of a word
    words = {{$urandom, $urandom}};
    build_model(16'h4000);
    grant_rnd = 1'b0;
    gcount = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h4000;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = words[0]; s_last = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk); #1;
      if (gcount >= 3) break;
    end
    chk("reset_test_three_bytes", gcount, 64'h3);
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, s_ready}, 64'h0);
    words = {{$urandom, $urandom}};
    run_session(16'h5000, 1'b1, 1'b0, 1'b0, -1);

    // Randomized sessions, some crossing the top of memory
    for (int k = 0; k < 8; k++) begin
      words.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) words.push_back({$urandom, $urandom});
      if (k % 3 == 2) b = 16'hFFE0 + 16'($urandom_range(0, 31));
      else            b = 16'($urandom_range(0, 16'hEF00));
      run_session(b, 1'b1, 1'b0, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
